// File: rtl/axil_uart_tx.sv
// AXI4-Lite console UART transmitter: TX FIFO, 8N1 serialiser, status and baud-divider registers.
// Optional build macro AXIL_UART_TX_IRQ_EN adds CTRL.irq_enable and the tx_irq output.
module axil_uart_tx #(
   parameter int FIFO_DEPTH     = 16,
   parameter int BAUD_DIV_RESET = 868,
   parameter int ADDR_LSB_WIDTH = 4
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] AXI_awaddr,
   input  logic [2:0]  AXI_awprot,
   input  logic        AXI_awvalid,
   output logic        AXI_awready,
   input  logic [31:0] AXI_wdata,
   input  logic [3:0]  AXI_wstrb,
   input  logic        AXI_wvalid,
   output logic        AXI_wready,
   output logic [1:0]  AXI_bresp,
   output logic        AXI_bvalid,
   input  logic        AXI_bready,
   input  logic [31:0] AXI_araddr,
   input  logic [2:0]  AXI_arprot,
   input  logic        AXI_arvalid,
   output logic        AXI_arready,
   output logic [31:0] AXI_rdata,
   output logic [1:0]  AXI_rresp,
   output logic        AXI_rvalid,
   input  logic        AXI_rready,
   output logic        uart_txd
`ifdef AXIL_UART_TX_IRQ_EN
   ,
   output logic        tx_irq
`endif
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int AW = ADDR_LSB_WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [AW-1:0] OFF_TXDATA = AW'(4'h0);
   localparam logic [AW-1:0] OFF_STATUS = AW'(4'h4);
   localparam logic [AW-1:0] OFF_BAUD   = AW'(4'h8);
   localparam logic [AW-1:0] OFF_CTRL   = AW'(4'hC);

   logic          r_awready, r_bvalid, r_arready, r_rvalid, r_txd, r_irq_en, r_tx_irq;
   logic [1:0]    r_bresp, r_rresp, r_state;
   logic [31:0]   r_rdata;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic [15:0]   r_baud, r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;

   logic [AW-1:0] w_awoff, w_aroff;
   logic          w_wr_hs, w_rd_hs, w_full, w_empty, w_push, w_pop, w_bit_end, w_txdata_wr;
   logic [15:0]   w_period, w_reload;
   logic [7:0]    w_head, w_cnt8;
   logic [31:0]   w_status, w_rdata;
   logic [1:0]    w_bresp, w_rresp;
   logic          w_unused;

   assign w_unused = ^{AXI_awprot, AXI_arprot, AXI_awaddr[31:AW], AXI_araddr[31:AW],
                       AXI_wdata[31:16], AXI_wstrb[3:2]};

   assign w_awoff     = AXI_awaddr[AW-1:0];
   assign w_aroff     = AXI_araddr[AW-1:0];
   assign w_wr_hs     = r_awready && AXI_awvalid && AXI_wvalid;
   assign w_rd_hs     = r_arready && AXI_arvalid;
   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_txdata_wr = w_wr_hs && (w_awoff == OFF_TXDATA) && AXI_wstrb[0];
   // Full is judged on the registered count, so a same-cycle pop never rescues a push.
   assign w_push      = w_txdata_wr && !w_full;
   assign w_bit_end   = (r_cnt == 16'd0);
   assign w_pop       = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
   assign w_period    = (r_baud < 16'd2) ? 16'd2 : r_baud;
   assign w_reload    = w_period - 16'd1;
   assign w_head      = r_mem[r_rptr];
   assign w_cnt8      = 8'(r_count);
   assign w_status    = {16'h0000, w_cnt8, 5'b00000, (r_state != S_IDLE), w_empty, w_full};

   assign AXI_awready = r_awready;
   assign AXI_wready  = r_awready;
   assign AXI_bvalid  = r_bvalid;
   assign AXI_bresp   = r_bresp;
   assign AXI_arready = r_arready;
   assign AXI_rvalid  = r_rvalid;
   assign AXI_rdata   = r_rdata;
   assign AXI_rresp   = r_rresp;
   assign uart_txd    = r_txd;
`ifdef AXIL_UART_TX_IRQ_EN
   assign tx_irq      = r_tx_irq;
`endif

   always_comb begin
      w_bresp = RESP_OKAY;
      if (w_txdata_wr && w_full)
         w_bresp = RESP_SLVERR;
      else if ((w_awoff != OFF_TXDATA) && (w_awoff != OFF_STATUS) &&
               (w_awoff != OFF_BAUD) && (w_awoff != OFF_CTRL))
         w_bresp = RESP_DECERR;
   end

   always_comb begin
      w_rdata = 32'h0;
      w_rresp = RESP_OKAY;
      case (w_aroff)
         OFF_TXDATA: w_rdata = 32'h0;
         OFF_STATUS: w_rdata = w_status;
         OFF_BAUD:   w_rdata = {16'h0000, r_baud};
`ifdef AXIL_UART_TX_IRQ_EN
         OFF_CTRL:   w_rdata = {31'h0, r_irq_en};
`else
         OFF_CTRL:   w_rdata = 32'h0;
`endif
         default:    w_rresp = RESP_DECERR;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= 32'h0;
         r_baud    <= 16'(BAUD_DIV_RESET);
         r_irq_en  <= 1'b0;
      end else begin
         r_awready <= !r_awready && AXI_awvalid && AXI_wvalid && !r_bvalid;
         r_arready <= !r_arready && AXI_arvalid && !r_rvalid;
         if (w_wr_hs) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_bresp;
         end else if (AXI_bready) begin
            r_bvalid <= 1'b0;
         end
         if (w_rd_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
            r_rresp  <= w_rresp;
         end else if (AXI_rready) begin
            r_rvalid <= 1'b0;
         end
         if (w_wr_hs && (w_awoff == OFF_BAUD)) begin
            if (AXI_wstrb[0]) r_baud[7:0]  <= AXI_wdata[7:0];
            if (AXI_wstrb[1]) r_baud[15:8] <= AXI_wdata[15:8];
         end
`ifdef AXIL_UART_TX_IRQ_EN
         if (w_wr_hs && (w_awoff == OFF_CTRL) && AXI_wstrb[0])
            r_irq_en <= AXI_wdata[0];
`endif
      end
   end

   always_ff @(posedge aclk) begin
      if (w_push) r_mem[r_wptr] <= AXI_wdata[7:0];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Serialiser: the bit counter reloads from BAUD_DIV at every bit boundary.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= S_IDLE;
         r_cnt     <= 16'd0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
         r_txd     <= 1'b1;
         r_tx_irq  <= 1'b0;
      end else begin
         r_txd    <= (r_state == S_START) ? 1'b0 : (r_state == S_DATA) ? r_shift[0] : 1'b1;
         r_tx_irq <= w_push ? 1'b0 : (r_irq_en && w_empty && (r_state == S_IDLE));
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_shift <= w_head;
                  r_cnt   <= w_reload;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_cnt     <= w_reload;
                  r_bit_idx <= 3'd0;
                  r_state   <= S_DATA;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt   <= w_reload;
                  r_shift <= r_shift >> 1;
                  if (r_bit_idx == 3'd7) r_state <= S_STOP;
                  else                   r_bit_idx <= r_bit_idx + 3'd1;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            default: begin
               if (w_bit_end) begin
                  // A queued byte starts its start bit straight after this stop bit.
                  if (w_pop) begin
                     r_shift <= w_head;
                     r_cnt   <= w_reload;
                     r_state <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axil_uart_tx.sv
// Scoreboard bench for axil_uart_tx: B/R responses checked by monitors, TXD waveform checked bit by bit.
module tb_axil_uart_tx;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] AXI_awaddr, AXI_wdata, AXI_araddr, AXI_rdata;
   logic [2:0]  AXI_awprot, AXI_arprot;
   logic [3:0]  AXI_wstrb;
   logic        AXI_awvalid, AXI_awready, AXI_wvalid, AXI_wready, AXI_bvalid, AXI_bready;
   logic        AXI_arvalid, AXI_arready, AXI_rvalid, AXI_rready;
   logic [1:0]  AXI_bresp, AXI_rresp;
   logic        uart_txd;
`ifdef AXIL_UART_TX_IRQ_EN
   logic        tx_irq;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   logic [1:0] bq[$];
   rexp_t      rq[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   axil_uart_tx dut (
      .aclk(aclk), .aresetn(aresetn),
      .AXI_awaddr(AXI_awaddr), .AXI_awprot(AXI_awprot), .AXI_awvalid(AXI_awvalid),
      .AXI_awready(AXI_awready), .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb),
      .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready), .AXI_bresp(AXI_bresp),
      .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready), .AXI_araddr(AXI_araddr),
      .AXI_arprot(AXI_arprot), .AXI_arvalid(AXI_arvalid), .AXI_arready(AXI_arready),
      .AXI_rdata(AXI_rdata), .AXI_rresp(AXI_rresp), .AXI_rvalid(AXI_rvalid),
      .AXI_rready(AXI_rready), .uart_txd(uart_txd)
`ifdef AXIL_UART_TX_IRQ_EN
      , .tx_irq(tx_irq)
`endif
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // Write-response monitor.
   always @(negedge aclk) begin
      if (aresetn && AXI_bvalid && AXI_bready) begin
         if (bq.size() == 0) fail_now("bresp_unexpected");
         else check("bresp", {30'b0, AXI_bresp}, {30'b0, bq.pop_front()});
      end
   end

   // Read-response monitor.
   always @(negedge aclk) begin
      if (aresetn && AXI_rvalid && AXI_rready) begin
         if (rq.size() == 0) fail_now("rresp_unexpected");
         else begin
            rexp_t e;
            e = rq.pop_front();
            check($sformatf("rdata@%0h", e.addr), AXI_rdata, e.data);
            check($sformatf("rresp@%0h", e.addr), {30'b0, AXI_rresp}, {30'b0, e.resp});
         end
      end
   end

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp);
      bit done = 0;
      bq.push_back(exp);
      @(posedge aclk); #1;
      AXI_awaddr = addr; AXI_wdata = data; AXI_wstrb = strb;
      AXI_awvalid = 1'b1; AXI_wvalid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge aclk);
         if (AXI_awready && AXI_wready) done = 1;
      end
      if (!done) fail_now($sformatf("write_timeout@%0h", addr));
      @(posedge aclk); #1;
      AXI_awvalid = 1'b0; AXI_wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
      bit    done = 0;
      rexp_t e;
      e.addr = addr; e.data = data; e.resp = resp;
      rq.push_back(e);
      @(posedge aclk); #1;
      AXI_araddr = addr; AXI_arvalid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge aclk);
         if (AXI_arready) done = 1;
      end
      if (!done) fail_now($sformatf("read_timeout@%0h", addr));
      @(posedge aclk); #1;
      AXI_arvalid = 1'b0;
   endtask

   task automatic drain();
      int i = 0;
      while ((bq.size() != 0 || rq.size() != 0) && i < 50) begin
         @(negedge aclk);
         i++;
      end
      if (bq.size() != 0 || rq.size() != 0) fail_now("drain");
   endtask

   // Expects start, 8 data bits LSB first, stop, each held exactly p cycles.
   task automatic check_frame(input logic [7:0] d, input int p, input int max_wait);
      bit found = 0;
      for (int i = 0; i < max_wait && !found; i++) begin
         @(negedge aclk);
         if (uart_txd == 1'b0) found = 1;
      end
      if (!found) fail_now($sformatf("start_bit_%02h", d));
      else begin
         for (int k = 0; k < 10 * p; k++) begin
            int   b;
            logic e;
            b = k / p;
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
            if (k > 0) @(negedge aclk);
            check($sformatf("txd_%02h_s%0d_b%0d", d, k, b), {31'b0, uart_txd}, {31'b0, e});
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit done;
      aresetn = 1'b0;
      AXI_awaddr = '0; AXI_awprot = '0; AXI_awvalid = 1'b0; AXI_wdata = '0; AXI_wstrb = '0;
      AXI_wvalid = 1'b0; AXI_bready = 1'b1; AXI_araddr = '0; AXI_arprot = '0;
      AXI_arvalid = 1'b0; AXI_rready = 1'b1;

      repeat (3) @(negedge aclk);
      check("rst_txd", {31'b0, uart_txd}, 32'd1);
      check("rst_awready", {31'b0, AXI_awready}, 32'd0);
      check("rst_bvalid", {31'b0, AXI_bvalid}, 32'd0);
      check("rst_rvalid", {31'b0, AXI_rvalid}, 32'd0);
      check("rst_rdata", AXI_rdata, 32'd0);
      @(posedge aclk); #2;
      aresetn = 1'b1;

      axi_read(32'h4, 32'h0000_0002, 2'b00);
      axi_read(32'h8, 32'h0000_0364, 2'b00);
      axi_read(32'h0, 32'h0000_0000, 2'b00);
      drain();

      // 0x55 at 4 cycles/bit; STATUS mid-frame shows busy with the FIFO already drained.
      axi_write(32'h8, 32'd4, 4'hF, 2'b00);
      axi_write(32'h0, 32'h55, 4'h1, 2'b00);
      fork
         axi_read(32'h4, 32'h0000_0006, 2'b00);
         check_frame(8'h55, 4, 20);
      join
      @(negedge aclk);
      check("idle_after_55", {31'b0, uart_txd}, 32'd1);
      axi_read(32'h4, 32'h0000_0002, 2'b00);

      axi_write(32'h0, 32'hAA, 4'b0010, 2'b00);
      axi_read(32'h4, 32'h0000_0002, 2'b00);
      axi_write(32'h8, 32'hABCD_1234, 4'b0010, 2'b00);
      axi_read(32'h8, 32'h0000_1204, 2'b00);

      // BAUD_DIV=1 clamps to 2 cycles/bit; two queued bytes run back-to-back.
      axi_write(32'h8, 32'd1, 4'hF, 2'b00);
      axi_read(32'h8, 32'h0000_0001, 2'b00);
      drain();
      fork
         begin
            axi_write(32'h0, 32'hC3, 4'h1, 2'b00);
            axi_write(32'h0, 32'h3C, 4'h1, 2'b00);
         end
         begin
            check_frame(8'hC3, 2, 20);
            check_frame(8'h3C, 2, 1);
         end
      join
      @(negedge aclk);
      check("idle_after_b2b", {31'b0, uart_txd}, 32'd1);
      drain();

      axi_read(32'h2, 32'h0, 2'b11);
      axi_read(32'hB, 32'h0, 2'b11);
      axi_write(32'h6, 32'h1, 4'hF, 2'b11);
      axi_write(32'h4, 32'hFFFF_FFFF, 4'hF, 2'b00);
      axi_read(32'h4, 32'h0000_0002, 2'b00);
      drain();

      // Slow baud: first byte is popped at once, the next 16 fill the FIFO, the 18th is dropped.
      axi_write(32'h8, 32'd1000, 4'hF, 2'b00);
      for (int i = 0; i < 18; i++)
         axi_write(32'h0, 32'h10 + i, 4'h1, (i < 17) ? 2'b00 : 2'b10);
      axi_read(32'h4, 32'h0000_1005, 2'b00);
      drain();

      // Held bready blocks the next write but not a read.
      AXI_bready = 1'b0;
      axi_write(32'h4, 32'h0, 4'hF, 2'b00);
      bq.push_back(2'b10);
      @(posedge aclk); #1;
      AXI_awaddr = 32'h0; AXI_wdata = 32'h99; AXI_wstrb = 4'h1;
      AXI_awvalid = 1'b1; AXI_wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         check("held_awready", {31'b0, AXI_awready}, 32'd0);
         check("held_bvalid", {31'b0, AXI_bvalid}, 32'd1);
      end
      axi_read(32'h8, 32'h0000_03E8, 2'b00);
      @(negedge aclk);
      check("held_wready", {31'b0, AXI_wready}, 32'd0);
      @(posedge aclk); #1;
      AXI_bready = 1'b1;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge aclk);
         if (AXI_awready) done = 1;
      end
      if (!done) fail_now("write_after_bready");
      @(posedge aclk); #1;
      AXI_awvalid = 1'b0; AXI_wvalid = 1'b0;
      drain();
      axi_read(32'h4, 32'h0000_1005, 2'b00);
      drain();

      // Asynchronous reset in the middle of a data bit.
      repeat (2000) @(negedge aclk);
      #3 aresetn = 1'b0;
      #1;
      check("midframe_rst_txd", {31'b0, uart_txd}, 32'd1);
      check("midframe_rst_bvalid", {31'b0, AXI_bvalid}, 32'd0);
      repeat (2) @(negedge aclk);
      @(posedge aclk); #2;
      aresetn = 1'b1;
      axi_read(32'h4, 32'h0000_0002, 2'b00);
      axi_read(32'h8, 32'h0000_0364, 2'b00);
      drain();

`ifdef AXIL_UART_TX_IRQ_EN
      axi_read(32'hC, 32'h0, 2'b00);
      axi_write(32'hC, 32'h1, 4'h1, 2'b00);
      repeat (3) @(negedge aclk);
      check("irq_set", {31'b0, tx_irq}, 32'd1);
      axi_read(32'hC, 32'h1, 2'b00);
      axi_write(32'h8, 32'd4, 4'hF, 2'b00);
      axi_write(32'h0, 32'hF0, 4'h1, 2'b00);
      @(negedge aclk);
      check("irq_cleared", {31'b0, tx_irq}, 32'd0);
      check_frame(8'hF0, 4, 20);
      repeat (3) @(negedge aclk);
      check("irq_after_frame", {31'b0, tx_irq}, 32'd1);
`else
      axi_write(32'hC, 32'h1, 4'hF, 2'b00);
      axi_read(32'hC, 32'h0, 2'b00);
`endif
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
